// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps the fetch PC, issues single-outstanding imem reads,
// buffers {word, pc} in a prefetch FIFO and hands words to decode with redirect/flush.
module instr_fetch_unit #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_VALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] INSTR_PC,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY
);
    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_e;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic          push, pop, issue;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^REDIRECT_PC[1:0];

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = 1'b0;
        addr_d   = addr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        push     = 1'b0;
        pop      = 1'b0;
        issue    = 1'b0;

        if (REDIRECT) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pc_d     = {REDIRECT_PC[31:2], 2'b00};
            // A request still in flight must have its response swallowed by FLUSH.
            state_d  = (state_q != ST_IDLE && !IMEM_VALID) ? ST_FLUSH : ST_IDLE;
        end else begin
            push = (state_q == ST_WAIT) && IMEM_VALID;
            pop  = valid_q && INSTR_READY;
            if (push) begin
                mem_d[wr_ptr_q].word = IMEM_RDATA;
                mem_d[wr_ptr_q].pc   = addr_q;
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);

            // Issue only when the response is guaranteed a free FIFO slot.
            case (state_q)
                ST_IDLE:  issue = (count_d < DEPTH_C);
                ST_WAIT: begin
                    if (IMEM_VALID) begin
                        if (count_d < DEPTH_C) issue   = 1'b1;
                        else                   state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: if (IMEM_VALID) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase

            if (issue) begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                pc_d    = pc_q + 32'd4;
                state_d = ST_WAIT;
            end
        end
        valid_d = (count_d != '0);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_VECTOR;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            // NOTE: FIFO storage is reset because the head outputs read it directly and must be 0.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            mem_q    <= mem_d;
        end
    end

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = addr_q;
    assign INSTRUCTION = mem_q[rd_ptr_q].word;
    assign INSTR_PC    = mem_q[rd_ptr_q].pc;
    assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the expected instruction stream is a sequential
// run of addresses from the last reset/redirect target; a monitor checks every accepted word.
module tb_instr_fetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] W_RV  = 32'hFFFF_FFF8;
    localparam logic [31:0] XMASK = 32'hA5A5_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_VALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] INSTRUCTION;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic        INSTR_READY;

    // Second instance: DEPTH=2, reset vector near the top of memory, always ready.
    logic        w_req, w_valid, w_instr_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc;
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;
    logic        w_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .CLK(CLK), .RESET(RESET),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_VALID(IMEM_VALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .INSTRUCTION(INSTRUCTION), .INSTR_PC(INSTR_PC),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY)
    );

    instr_fetch_unit #(.DEPTH(2), .RESET_VECTOR(W_RV)) dut_w (
        .CLK(CLK), .RESET(RESET),
        .IMEM_REQ(w_req), .IMEM_ADDR(w_addr),
        .IMEM_VALID(w_valid), .IMEM_RDATA(w_rdata),
        .REDIRECT(w_redirect), .REDIRECT_PC(w_redirect_pc),
        .INSTRUCTION(w_instr), .INSTR_PC(w_pc),
        .INSTR_VALID(w_instr_valid), .INSTR_READY(w_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic restart_model(input logic [31:0] target);
        exp_t        e;
        logic [31:0] a;
        a = {target[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            e.pc   = a;
            e.word = a ^ XMASK;
            exp_q.push_back(e);
            a = a + 32'd4;
        end
    endtask

    // Instruction memory models (main: fixed or random latency; w: 1 cycle).
    int          fixed_lat = 1;
    bit          rand_lat  = 1'b0;
    bit          mem_pend  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_addr  = 32'h0;
    bit          w_pend    = 1'b0;
    logic [31:0] w_addr_l  = 32'h0;

    task automatic mem_tick();
        IMEM_VALID = 1'b0;
        w_valid    = 1'b0;
        if (!RESET) begin
            mem_pend = 1'b0;
            w_pend   = 1'b0;
        end else begin
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    IMEM_VALID = 1'b1;
                    IMEM_RDATA = mem_addr ^ XMASK;
                    mem_pend   = 1'b0;
                end
            end
            if (IMEM_REQ) begin
                mem_pend = 1'b1;
                mem_addr = IMEM_ADDR;
                mem_cnt  = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
            end
            if (w_pend) begin
                w_valid = 1'b1;
                w_rdata = w_addr_l ^ XMASK;
                w_pend  = 1'b0;
            end
            if (w_req) begin
                w_pend   = 1'b1;
                w_addr_l = w_addr;
            end
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        mem_tick();
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    logic [31:0] req_exp, w_req_exp, w_pop_exp, hold_pc, hold_instr;
    int          reqs_since, acc_since;
    bit          outstanding, hold_prev;
    exp_t        e_mon;

    always begin
        @(negedge CLK);
        #4;
        if (!RESET) begin
            req_exp     = RV;
            reqs_since  = 0;
            acc_since   = 0;
            outstanding = 1'b0;
            hold_prev   = 1'b0;
            w_req_exp   = W_RV;
            w_pop_exp   = W_RV;
        end else begin
            if (IMEM_REQ) begin
                check("req_addr", IMEM_ADDR, req_exp);
                check("one_outstanding", 32'(outstanding), 32'd0);
                check("credit", 32'(reqs_since + 1 - acc_since <= DEPTH), 32'd1);
                req_exp     = req_exp + 32'd4;
                reqs_since++;
                outstanding = 1'b1;
            end
            if (IMEM_VALID) outstanding = 1'b0;
            if (hold_prev) begin
                check("hold_valid", 32'(INSTR_VALID), 32'd1);
                check("hold_pc", INSTR_PC, hold_pc);
                check("hold_instr", INSTRUCTION, hold_instr);
            end
            if (REDIRECT) begin
                req_exp    = {REDIRECT_PC[31:2], 2'b00};
                reqs_since = 0;
                acc_since  = 0;
                hold_prev  = 1'b0;
            end else begin
                if (INSTR_VALID && INSTR_READY) begin
                    if (exp_q.size() == 0) begin
                        fail_now("scoreboard_underflow");
                    end else begin
                        e_mon = exp_q.pop_front();
                        check("instr_pc", INSTR_PC, e_mon.pc);
                        check("instruction", INSTRUCTION, e_mon.word);
                    end
                    acc_since++;
                end
                hold_prev  = INSTR_VALID && !INSTR_READY;
                hold_pc    = INSTR_PC;
                hold_instr = INSTRUCTION;
            end
            if (w_req) begin
                check("wrap_req_addr", w_addr, w_req_exp);
                w_req_exp = w_req_exp + 32'd4;
            end
            if (w_instr_valid) begin
                check("wrap_instr_pc", w_pc, w_pop_exp);
                check("wrap_instruction", w_instr, w_pop_exp ^ XMASK);
                w_pop_exp = w_pop_exp + 32'd4;
            end
        end
    end

    function automatic bit cond(input int kind);
        case (kind)
            0:       return IMEM_REQ;
            1:       return IMEM_REQ && (IMEM_ADDR == 32'h8);
            2:       return INSTR_VALID;
            default: return IMEM_VALID && INSTR_VALID;
        endcase
    endfunction

    task automatic wait_for(input int kind, input string name, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            cycle();
            #1;
            if (cond(kind)) seen = 1'b1;
        end
        if (!seen) fail_now({name, " timeout"});
    endtask

    task automatic do_reset(input logic ready);
        cycle();
        RESET       = 1'b0;
        REDIRECT    = 1'b0;
        INSTR_READY = ready;
        restart_model(RV);
        cycle();
        cycle();
        #1;
        check("rst_imem_req", 32'(IMEM_REQ), 32'd0);
        check("rst_imem_addr", IMEM_ADDR, 32'd0);
        check("rst_instruction", INSTRUCTION, 32'd0);
        check("rst_instr_pc", INSTR_PC, 32'd0);
        check("rst_instr_valid", 32'(INSTR_VALID), 32'd0);
        RESET = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET       = 1'b0;
        IMEM_VALID  = 1'b0;
        IMEM_RDATA  = 32'h0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'h0;
        INSTR_READY = 1'b1;
        w_valid     = 1'b0;
        w_rdata     = 32'h0;
        restart_model(RV);

        // Reset and stream with 1-cycle memory.
        fixed_lat = 1;
        do_reset(1'b1);
        cycle(); #1;
        check("first_req_c1", 32'(IMEM_REQ), 32'd1);
        check("first_addr_c1", IMEM_ADDR, RV);
        cycle(); #1;
        check("valid_low_c2", 32'(INSTR_VALID), 32'd0);
        cycle(); #1;
        check("valid_high_c3", 32'(INSTR_VALID), 32'd1);
        check("first_word_c3", INSTRUCTION, 32'hA5A5_0000);
        repeat (12) cycle();

        // Backpressure: FIFO fills with exactly DEPTH words, then fetch stalls.
        do_reset(1'b0);
        repeat (20) cycle();
        #1;
        check("bp_request_count", 32'(reqs_since), 32'd4);
        check("bp_req_idle", 32'(IMEM_REQ), 32'd0);
        check("bp_head_pc", INSTR_PC, 32'h0);
        check("bp_head_word", INSTRUCTION, 32'hA5A5_0000);
        INSTR_READY = 1'b1;
        wait_for(0, "bp_resume", 20);
        check("bp_resume_addr", IMEM_ADDR, 32'h10);
        repeat (12) cycle();

        // Redirect one cycle after the request for 0x8 with 3-cycle memory.
        fixed_lat = 3;
        do_reset(1'b1);
        wait_for(1, "req_0x8", 30);
        cycle();
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0103;
        restart_model(32'h0000_0103);
        cycle();
        REDIRECT = 1'b0;
        #1;
        check("redir_fifo_empty", 32'(INSTR_VALID), 32'd0);
        wait_for(0, "redir_req", 20);
        check("redir_addr", IMEM_ADDR, 32'h0000_0100);
        wait_for(2, "redir_valid", 20);
        check("redir_head_pc", INSTR_PC, 32'h0000_0100);
        repeat (10) cycle();

        // Redirect coincident with a pop and a response.
        fixed_lat = 1;
        do_reset(1'b0);
        repeat (6) cycle();
        INSTR_READY = 1'b1;
        wait_for(3, "pop_and_resp", 20);
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_2000;
        restart_model(32'h0000_2000);
        cycle();
        REDIRECT = 1'b0;
        #1;
        check("coinc_valid_low", 32'(INSTR_VALID), 32'd0);
        wait_for(0, "coinc_req", 20);
        check("coinc_addr", IMEM_ADDR, 32'h0000_2000);
        repeat (10) cycle();

        // Asynchronous reset while a request is outstanding.
        fixed_lat = 3;
        do_reset(1'b1);
        wait_for(0, "async_req", 20);
        cycle();
        #2;
        RESET = 1'b0;
        restart_model(RV);
        #1;
        check("async_imem_req", 32'(IMEM_REQ), 32'd0);
        check("async_imem_addr", IMEM_ADDR, 32'd0);
        check("async_instruction", INSTRUCTION, 32'd0);
        check("async_instr_pc", INSTR_PC, 32'd0);
        check("async_instr_valid", 32'(INSTR_VALID), 32'd0);
        cycle();
        RESET      = 1'b1;
        IMEM_VALID = 1'b1;
        IMEM_RDATA = 32'hDEAD_BEEF;
        cycle();
        #1;
        check("async_restart_req", 32'(IMEM_REQ), 32'd1);
        check("async_restart_addr", IMEM_ADDR, RV);
        repeat (20) cycle();

        // Randomized traffic: random latency, backpressure and redirects.
        rand_lat = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 1500; i++) begin
            cycle();
            INSTR_READY = ($urandom_range(0, 3) != 0);
            REDIRECT    = ($urandom_range(0, 24) == 0);
            if (REDIRECT) begin
                REDIRECT_PC = $urandom;
                if ($urandom_range(0, 3) == 0) REDIRECT_PC = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                restart_model(REDIRECT_PC);
            end
        end
        cycle();
        REDIRECT    = 1'b0;
        INSTR_READY = 1'b1;
        repeat (20) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
